// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU serial path: UART defaults, frame geometry
// and the transmitter state encoding with its line-level helper.
package gpu_pkg;

    localparam int UART_DIVISOR_DEFAULT = 434;
    localparam int FRAME_BITS           = 10;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Line level the transmitter drives while in a given state.
    function automatic logic tx_line_level(input tx_state_t state, input logic data_bit);
        logic lvl;
        case (state)
            TX_START: lvl = 1'b0;
            TX_DATA:  lvl = data_bit;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/ansi_serial_tx_byte_fifo.sv
// Single-clock byte FIFO with first-word fall-through read data.
// A push while full is ignored even if a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [7:0]            i_din,
    output logic [7:0]            o_dout,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    assign o_full    = (r_count == (DEPTH_LOG2+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ansi_serial_tx.sv
// Buffered 8N1 UART transmitter fed by the GPU serial frontend; frames are
// sent back to back while the FIFO holds data.
module ansi_serial_tx
    import gpu_pkg::*;
#(
    parameter int DIVISOR    = UART_DIVISOR_DEFAULT,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [7:0]            STX_DATA,
    input  logic                  STX_SEND,
    output logic                  STX_READY,
    output logic                  TXD,
    output logic                  TX_BUSY,
    output logic [DEPTH_LOG2:0]   FIFO_LEVEL,
    output logic                  OVERFLOW
);

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [15:0] r_baud;
    logic [15:0] w_baud_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_txd;
    logic        w_txd_nxt;
    logic        r_overflow;
    logic        w_pop;
    logic        w_tick;
    logic [7:0]  w_dout;
    logic        w_full;
    logic        w_empty;

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (STX_SEND),
        .i_pop   (w_pop),
        .i_din   (STX_DATA),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (FIFO_LEVEL)
    );

    assign w_tick    = (r_baud == 16'(DIVISOR - 1));
    assign STX_READY = !w_full;
    assign TX_BUSY   = (r_state != TX_IDLE) || !w_empty;
    assign TXD       = r_txd;
    assign OVERFLOW  = r_overflow;

    // Frame sequencing: pops the next byte at IDLE or at the end of STOP so
    // consecutive frames share no idle gap.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_pop       = 1'b0;
        w_baud_nxt  = r_baud + 16'd1;
        case (r_state)
            TX_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_dout;
                    w_state_nxt = TX_START;
                end else begin
                    w_state_nxt = TX_IDLE;
                end
            end
            TX_START: begin
                if (w_tick) begin
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = TX_DATA;
                end else begin
                    w_state_nxt = TX_START;
                end
            end
            TX_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = TX_STOP;
                    end else begin
                        w_state_nxt = TX_DATA;
                    end
                end else begin
                    w_state_nxt = TX_DATA;
                end
            end
            TX_STOP: begin
                if (w_tick) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_dout;
                        w_state_nxt = TX_START;
                    end else begin
                        w_state_nxt = TX_IDLE;
                    end
                end else begin
                    w_state_nxt = TX_STOP;
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
            end
        endcase
        if (w_pop || w_tick || (w_state_nxt == TX_IDLE)) begin
            w_baud_nxt = 16'd0;
        end else begin
            w_baud_nxt = r_baud + 16'd1;
        end
        w_txd_nxt = tx_line_level(w_state_nxt, w_shift_nxt[0]);
    end

    // State, counters, line register and sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= TX_IDLE;
            r_baud     <= 16'd0;
            r_bit      <= 3'd0;
            r_shift    <= 8'd0;
            r_txd      <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
            if (STX_SEND && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ansi_serial_tx.sv
// Self-checking bench for ansi_serial_tx: constant vectors, directed corner
// sequences and random traffic against a frame-timeline reference model.
module tb_ansi_serial_tx;
    import gpu_pkg::*;

    localparam int D  = 4;
    localparam int DL = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       STX_SEND = 1'b0;
    logic [7:0] STX_DATA = 8'h00;
    logic       STX_READY;
    logic       TXD;
    logic       TX_BUSY;
    logic       OVERFLOW;
    logic [DL:0] FIFO_LEVEL;

    ansi_serial_tx #(.DIVISOR(D), .DEPTH_LOG2(DL)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .STX_DATA   (STX_DATA),
        .STX_SEND   (STX_SEND),
        .STX_READY  (STX_READY),
        .TXD        (TXD),
        .TX_BUSY    (TX_BUSY),
        .FIFO_LEVEL (FIFO_LEVEL),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: a queue of waiting bytes and the position inside the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_active = 1'b0;
    int         m_t = 0;
    bit         m_ovf = 1'b0;

    task automatic model_edge(input logic rst, input logic snd, input logic [7:0] d);
        int sz;
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_t = 0;
            m_ovf = 1'b0;
        end else begin
            sz = mq.size();
            if (m_active) begin
                m_t++;
                if (m_t == FRAME_BITS * D) begin
                    m_t = 0;
                    if (sz > 0) m_cur = mq.pop_front();
                    else m_active = 1'b0;
                end
            end else if (sz > 0) begin
                m_cur = mq.pop_front();
                m_active = 1'b1;
                m_t = 0;
            end
            if (snd) begin
                if (sz < (1 << DL)) mq.push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endtask

    function automatic logic m_txd();
        int b;
        if (!m_active) return 1'b1;
        b = m_t / D;
        if (b == 0) return 1'b0;
        if (b == FRAME_BITS - 1) return 1'b1;
        return m_cur[b-1];
    endfunction

    // Line receiver: mid-bit sampling of TXD into a byte queue.
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte = 8'h00;
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;

    always @(negedge CLK) begin
        if (RESET) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (TXD === 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % D == D / 2) begin
                if (rx_cnt / D >= 1 && rx_cnt / D <= 8) begin
                    rx_byte[rx_cnt / D - 1] <= TXD;
                end else if (rx_cnt / D == 9) begin
                    chk("rx_stop_bit", 32'(TXD), 32'd1);
                    rx_q.push_back(rx_byte);
                    rx_act <= 1'b0;
                end
            end
        end
    end

    task automatic step(input logic rst, input logic snd, input logic [7:0] d);
        RESET = rst;
        STX_SEND = snd;
        STX_DATA = d;
        @(posedge CLK);
        cyc++;
        model_edge(rst, snd, d);
        #1;
        chk("model_txd", 32'(TXD), 32'(m_txd()));
        chk("model_level", 32'(FIFO_LEVEL), 32'(mq.size()));
        chk("model_ready", 32'(STX_READY), 32'(mq.size() != (1 << DL)));
        chk("model_busy", 32'(TX_BUSY), 32'(m_active || mq.size() != 0));
        chk("model_overflow", 32'(OVERFLOW), 32'(m_ovf));
    endtask

    task automatic drain(input string name, input int max_cyc);
        for (int n = 0; n < max_cyc && TX_BUSY !== 1'b0; n++) step(1'b0, 1'b0, 8'h00);
        chk({name, "_drain"}, 32'(TX_BUSY), 32'd0);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp_q[$]);
        chk({name, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk({name, "_rx_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    typedef struct {
        logic       rst;
        logic       snd;
        logic [7:0] d;
        logic       e_txd;
        logic [4:0] e_lvl;
        logic       e_rdy;
        logic       e_busy;
        logic       e_ovf;
    } vec_t;

    initial begin
        vec_t       tbl[6];
        logic [7:0] expq[$];
        logic [7:0] burst[6];
        bit         fbits[10];
        int         busy_cnt;
        int         e0;
        int         p;

        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h1B, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0};
        fbits  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        burst  = '{8'h1B, 8'h5B, 8'h3F, 8'h32, 8'h35, 8'h6C};

        // Reset and first byte 0x1B: table rows then the rest of its frame.
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].rst, tbl[i].snd, tbl[i].d);
            chk("tbl_txd", 32'(TXD), 32'(tbl[i].e_txd));
            chk("tbl_level", 32'(FIFO_LEVEL), 32'(tbl[i].e_lvl));
            chk("tbl_ready", 32'(STX_READY), 32'(tbl[i].e_rdy));
            chk("tbl_busy", 32'(TX_BUSY), 32'(tbl[i].e_busy));
            chk("tbl_overflow", 32'(OVERFLOW), 32'(tbl[i].e_ovf));
        end
        for (int k = 2; k < 40; k++) begin
            step(1'b0, 1'b0, 8'h00);
            chk("single_txd", 32'(TXD), 32'(fbits[k / D]));
            chk("single_busy", 32'(TX_BUSY), 32'd1);
        end
        step(1'b0, 1'b0, 8'h00);
        chk("single_busy_drop", 32'(TX_BUSY), 32'd0);
        chk("single_idle_txd", 32'(TXD), 32'd1);
        expq.delete();
        expq.push_back(8'h1B);
        check_rx("single", expq);

        // Burst "ESC[?25l", one push every 2 cycles: frames must be contiguous.
        rx_q.delete();
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, burst[i]);
            busy_cnt += int'(TX_BUSY);
            step(1'b0, 1'b0, 8'h00);
            busy_cnt += int'(TX_BUSY);
        end
        for (int n = 0; n < 400 && TX_BUSY !== 1'b0; n++) begin
            step(1'b0, 1'b0, 8'h00);
            busy_cnt += int'(TX_BUSY);
        end
        chk("burst_busy_cycles", 32'(busy_cnt), 32'(1 + 6 * FRAME_BITS * D));
        expq.delete();
        for (int i = 0; i < 6; i++) expq.push_back(burst[i]);
        check_rx("burst", expq);

        // Overflow: 18 pushes every 2 cycles, the 18th is dropped.
        step(1'b1, 1'b0, 8'h00);
        rx_q.delete();
        expq.delete();
        e0 = 0;
        for (int k = 1; k <= 18; k++) begin
            step(1'b0, 1'b1, 8'(k * 13 + 7));
            if (k == 1) e0 = cyc;
            if (k <= 17) expq.push_back(8'(k * 13 + 7));
            if (k == 17) begin
                chk("ovf_ready_low", 32'(STX_READY), 32'd0);
                chk("ovf_level_full", 32'(FIFO_LEVEL), 32'd16);
            end
            if (k == 18) begin
                chk("ovf_flag", 32'(OVERFLOW), 32'd1);
                chk("ovf_level_held", 32'(FIFO_LEVEL), 32'd16);
            end
            step(1'b0, 1'b0, 8'h00);
        end
        for (int n = 0; n < 100 && STX_READY !== 1'b1; n++) step(1'b0, 1'b0, 8'h00);
        chk("ovf_ready_return_cycle", 32'(cyc - e0), 32'(1 + FRAME_BITS * D));
        drain("ovf", 17 * FRAME_BITS * D + 50);
        check_rx("ovf", expq);
        chk("ovf_sticky", 32'(OVERFLOW), 32'd1);

        // Push coinciding with the STOP->START pop at level 3.
        step(1'b1, 1'b0, 8'h00);
        rx_q.delete();
        expq.delete();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 8'(8'hC0 + k));
            if (k == 0) e0 = cyc;
            expq.push_back(8'(8'hC0 + k));
        end
        chk("simul_level_start", 32'(FIFO_LEVEL), 32'd3);
        for (int n = 0; n < 60 && (cyc - e0) < FRAME_BITS * D; n++) step(1'b0, 1'b0, 8'h00);
        chk("simul_level_before", 32'(FIFO_LEVEL), 32'd3);
        step(1'b0, 1'b1, 8'hC4);
        expq.push_back(8'hC4);
        chk("simul_level_after", 32'(FIFO_LEVEL), 32'd3);
        chk("simul_restart_txd", 32'(TXD), 32'd0);
        drain("simul", 6 * FRAME_BITS * D);
        check_rx("simul", expq);

        // Reset during DATA bit 4 with a full FIFO and OVERFLOW set.
        step(1'b1, 1'b0, 8'h00);
        rx_q.delete();
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 1'b1, 8'(8'h40 + k));
            if (k == 0) e0 = cyc;
        end
        chk("mid_ovf_set", 32'(OVERFLOW), 32'd1);
        for (int n = 0; n < 20 && (cyc - e0) < 22; n++) step(1'b0, 1'b0, 8'h00);
        chk("mid_data_bit4", 32'(TXD), 32'd0);
        step(1'b1, 1'b0, 8'h00);
        chk("mid_rst_txd", 32'(TXD), 32'd1);
        chk("mid_rst_level", 32'(FIFO_LEVEL), 32'd0);
        chk("mid_rst_ovf", 32'(OVERFLOW), 32'd0);
        chk("mid_rst_busy", 32'(TX_BUSY), 32'd0);
        step(1'b0, 1'b1, 8'hA5);
        drain("mid", 2 * FRAME_BITS * D);
        expq.delete();
        expq.push_back(8'hA5);
        check_rx("mid", expq);

        // Random traffic with varying push density and rare resets.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 1500; i++) begin
            p = (i < 500) ? 85 : ((i < 1000) ? 4 : 35);
            step($urandom_range(0, 599) == 0, $urandom_range(0, 99) < p, 8'($urandom));
        end
        drain("rand", 17 * FRAME_BITS * D + 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
